// File: rtl/pixel_window_packer.sv
// pixel_window_packer: gathers DEPTH pixels into a window and hands it to a double-buffered output register
module pixel_window_packer #(
  parameter int PIXEL_W = 32,
  parameter int DEPTH   = 9,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       reset_FSM,
  input  logic [PIXEL_W-1:0]         pixel,
  input  logic                       ren,
  output logic                       in_ready,
  input  logic                       flush,
  output logic [DEPTH*PIXEL_W-1:0]   out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CNT_W-1:0]           win_count,
  output logic                       overflow
);
  localparam int QW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;
  state_t                     state_q, state_d;
  logic [QW-1:0]              q_q, q_d;
  logic [DEPTH*PIXEL_W-1:0]   fill_q, fill_d, out_q, out_d;
  logic                       out_valid_q, out_valid_d;
  logic [CNT_W-1:0]           win_count_q, win_count_d;
  logic                       overflow_q, overflow_d;
  logic                       accept, drain, last, xfer;
  assign in_ready  = (state_q != HOLD) & !flush;
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign win_count = win_count_q;
  assign overflow  = overflow_q;
  // Next-state: slot write, window hand-off to the output buffer, counters and sticky overflow
  always_comb begin
    accept = ren & in_ready;
    drain  = out_valid_q & out_ready;
    last   = accept & (q_q == QW'(DEPTH - 1));
    xfer   = (last & (!out_valid_q | out_ready)) | (!flush & (state_q == HOLD) & drain);
    fill_d = fill_q;
    for (int k = 0; k < DEPTH; k++)
      if (accept && q_q == QW'(k)) fill_d[k*PIXEL_W +: PIXEL_W] = pixel;
    q_d         = (flush | last) ? '0 : accept ? q_q + 1'b1 : q_q;
    state_d     = flush ? IDLE :
                  (state_q == HOLD) ? (drain ? IDLE : HOLD) :
                  last ? (xfer ? IDLE : HOLD) :
                  accept ? FILL : state_q;
    out_d       = xfer ? fill_d : out_q;
    out_valid_d = xfer | (out_valid_q & !out_ready);
    win_count_d = win_count_q + CNT_W'(drain);
    overflow_d  = overflow_q | (ren & !in_ready & !flush);
  end
  // State registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset_FSM) begin
    if (reset_FSM) begin
      state_q     <= IDLE;
      q_q         <= '0;
      fill_q      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      win_count_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      q_q         <= q_d;
      fill_q      <= fill_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      win_count_q <= win_count_d;
      overflow_q  <= overflow_d;
    end
  end
endmodule

// File: tb/tb_pixel_window_packer.sv
// tb_pixel_window_packer: scoreboard bench with a queue-level reference model
module tb_pixel_window_packer;
  localparam int PW = 32;
  localparam int D  = 9;
  localparam int CW = 16;
  localparam int N  = D * PW;
  logic          clk = 1'b0;
  logic          reset_FSM;
  logic [PW-1:0] pixel;
  logic          ren, flush, out_ready;
  logic          in_ready, out_valid, overflow;
  logic [N-1:0]  out;
  logic [CW-1:0] win_count;
  int checks = 0;
  int errors = 0;
  bit started = 0;
  logic [PW-1:0] cur[$];
  logic [N-1:0]  exp_q[$];
  logic [N-1:0]  pend;
  bit            pend_v, obuf_full, ovf;
  logic [CW-1:0] wc;

  pixel_window_packer #(.PIXEL_W(PW), .DEPTH(D), .CNT_W(CW)) dut (
    .clk(clk), .reset_FSM(reset_FSM), .pixel(pixel), .ren(ren), .in_ready(in_ready),
    .flush(flush), .out(out), .out_valid(out_valid), .out_ready(out_ready),
    .win_count(win_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] pack_cur();
    logic [N-1:0] w = '0;
    for (int k = 0; k < D; k++) w[k*PW +: PW] = cur[k];
    return w;
  endfunction

  task automatic model_reset();
    cur.delete();
    exp_q.delete();
    pend_v = 0; obuf_full = 0; ovf = 0; wc = '0; pend = '0;
  endtask

  // Reference: windows are lists of accepted pixels; one window may wait while the output slot is busy
  task automatic model_edge();
    bit drain = obuf_full && out_ready;
    bit xfer = 0;
    if (flush) begin
      cur.delete();
      pend_v = 0;
    end else if (pend_v) begin
      if (ren) ovf = 1;
      if (drain) begin exp_q.push_back(pend); pend_v = 0; xfer = 1; end
    end else if (ren) begin
      cur.push_back(pixel);
      if (cur.size() == D) begin
        if (!obuf_full || out_ready) begin exp_q.push_back(pack_cur()); xfer = 1; end
        else begin pend = pack_cur(); pend_v = 1; end
        cur.delete();
      end
    end
    if (drain) wc = wc + 1'b1;
    obuf_full = xfer || (obuf_full && !out_ready);
  endtask

  task automatic step(input bit r, input logic [PW-1:0] p, input bit f, input bit o);
    ren = r; pixel = p; flush = f; out_ready = o;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic window(input logic [PW-1:0] base, input bit o);
    for (int i = 0; i < D; i++) step(1, base + PW'(i), 0, o);
  endtask

  task automatic idle(input int n, input bit o);
    for (int i = 0; i < n; i++) step(0, '0, 0, o);
  endtask

  // Monitor: compares status every cycle and pops the scoreboard on each consumed window
  always @(negedge clk) begin
    if (started && !reset_FSM) begin
      chk("out_valid", N'(out_valid), N'(obuf_full));
      chk("in_ready", N'(in_ready), N'(!pend_v && !flush));
      chk("overflow", N'(overflow), N'(ovf));
      chk("win_count", N'(win_count), N'(wc));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL window_unexpected got %h expected none", out);
        end else chk("window", out, exp_q.pop_front());
      end
    end
  end

  initial begin
    reset_FSM = 1; ren = 0; pixel = '0; flush = 0; out_ready = 0;
    model_reset();
    #2;
    chk("rst_out_valid", N'(out_valid), '0);
    chk("rst_out", out, '0);
    chk("rst_win_count", N'(win_count), '0);
    chk("rst_overflow", N'(overflow), '0);
    chk("rst_in_ready", N'(in_ready), N'(1));
    @(posedge clk); #1;
    reset_FSM = 0; started = 1;
    window(32'h00, 1);
    idle(2, 1);
    for (int i = 0; i < D; i++) begin
      step(1, PW'(i), 0, 1);
      if (i == 2 || i == 5) idle(3, 1);
    end
    idle(2, 1);
    window(32'h10, 0);
    window(32'h20, 0);
    step(1, 32'h99, 0, 0);
    step(0, '0, 0, 1);
    idle(2, 0);
    idle(2, 1);
    for (int i = 0; i < 4; i++) step(1, 32'hA0 + PW'(i), 0, 1);
    step(1, 32'hEE, 1, 1);
    window(32'h30, 1);
    idle(2, 1);
    window(32'h40, 0);
    for (int i = 0; i < 5; i++) step(1, 32'h50 + PW'(i), 0, 0);
    reset_FSM = 1;
    #1;
    chk("midrst_out_valid", N'(out_valid), '0);
    chk("midrst_out", out, '0);
    chk("midrst_win_count", N'(win_count), '0);
    chk("midrst_overflow", N'(overflow), '0);
    model_reset();
    #1 reset_FSM = 0;
    window(32'h60, 1);
    idle(2, 1);
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6);
    idle(4, 1);
    chk("scoreboard_empty", N'(exp_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
